// File: rtl/serdes_status_filter_pkg.sv
// Shared constants and types for the SERDES status-flag conditioning path.
package serdes_status_filter_pkg;

  localparam int unsigned FILT_CNT_W = 8;

  // Filtered flags come out of reset in the loss state.
  localparam logic FLAG_RST_VAL = 1'b1;

  localparam logic [7:0] LOSS_CNT_MAX = 8'd255;

  typedef logic [FILT_CNT_W-1:0] filt_cnt_t;

  // A flag needs a short run to assert and a long run to clear.
  function automatic filt_cnt_t filt_limit(input logic cur_out,
                                           input filt_cnt_t assert_lim,
                                           input filt_cnt_t deassert_lim);
    return cur_out ? deassert_lim : assert_lim;
  endfunction

endpackage

// File: rtl/serdes_status_filter_flag.sv
// One raw status flag: 2-flop synchroniser followed by an asymmetric debounce.
module status_flag_filter
  import serdes_status_filter_pkg::*;
#(
  parameter int unsigned ASSERT_CYC   = 2,
  parameter int unsigned DEASSERT_CYC = 16
) (
  input  logic refclkdiv2,
  input  logic rst,
  input  logic raw,
  output logic filt
);

  localparam filt_cnt_t ASSERT_LIM   = filt_cnt_t'(ASSERT_CYC);
  localparam filt_cnt_t DEASSERT_LIM = filt_cnt_t'(DEASSERT_CYC);

  logic      sy1;
  logic      sy2;
  filt_cnt_t cnt;
  filt_cnt_t limit;

  assign limit = filt_limit(filt, ASSERT_LIM, DEASSERT_LIM);

  always_ff @(posedge refclkdiv2 or posedge rst) begin
    if (rst) begin
      sy1 <= FLAG_RST_VAL;
      sy2 <= FLAG_RST_VAL;
    end else begin
      sy1 <= raw;
      sy2 <= sy1;
    end
  end

  // Any cycle where the synchronised input agrees with the output restarts the run.
  always_ff @(posedge refclkdiv2 or posedge rst) begin
    if (rst) begin
      filt <= FLAG_RST_VAL;
      cnt  <= '0;
    end else if (sy2 == filt) begin
      cnt <= '0;
    end else if (cnt + filt_cnt_t'(1) == limit) begin
      filt <= ~filt;
      cnt  <= '0;
    end else begin
      cnt <= cnt + filt_cnt_t'(1);
    end
  end

endmodule

// File: rtl/serdes_status_filter.sv
// Synchronises and debounces SERDES status flags and counts receive loss events.
module serdes_status_filter
  import serdes_status_filter_pkg::*;
#(
  parameter int unsigned ASSERT_CYC   = 2,
  parameter int unsigned DEASSERT_CYC = 16
) (
  input  logic       refclkdiv2,
  input  logic       rst,
  input  logic       rx_cdr_lol_ch,
  input  logic       rx_los_low_ch,
  input  logic       tx_pll_lol_qd,
  input  logic       clr_cnt,
  output logic       rx_cdr_lol_ch_s,
  output logic       rx_los_low_ch_s,
  output logic       tx_pll_lol_qd_s,
  output logic       rx_loss_pulse,
  output logic [7:0] rx_loss_cnt
);

  logic loss_now;
  logic loss_d;

  status_flag_filter #(
    .ASSERT_CYC  (ASSERT_CYC),
    .DEASSERT_CYC(DEASSERT_CYC)
  ) u_cdr_filt (
    .refclkdiv2(refclkdiv2),
    .rst       (rst),
    .raw       (rx_cdr_lol_ch),
    .filt      (rx_cdr_lol_ch_s)
  );

  status_flag_filter #(
    .ASSERT_CYC  (ASSERT_CYC),
    .DEASSERT_CYC(DEASSERT_CYC)
  ) u_los_filt (
    .refclkdiv2(refclkdiv2),
    .rst       (rst),
    .raw       (rx_los_low_ch),
    .filt      (rx_los_low_ch_s)
  );

  status_flag_filter #(
    .ASSERT_CYC  (ASSERT_CYC),
    .DEASSERT_CYC(DEASSERT_CYC)
  ) u_pll_filt (
    .refclkdiv2(refclkdiv2),
    .rst       (rst),
    .raw       (tx_pll_lol_qd),
    .filt      (tx_pll_lol_qd_s)
  );

  assign loss_now      = rx_cdr_lol_ch_s | rx_los_low_ch_s;
  assign rx_loss_pulse = loss_now & ~loss_d;

  // loss_d resets high so leaving reset in the loss state is not counted as an event.
  always_ff @(posedge refclkdiv2 or posedge rst) begin
    if (rst) begin
      loss_d <= FLAG_RST_VAL;
    end else begin
      loss_d <= loss_now;
    end
  end

  always_ff @(posedge refclkdiv2 or posedge rst) begin
    if (rst) begin
      rx_loss_cnt <= '0;
    end else if (clr_cnt) begin
      rx_loss_cnt <= '0;
    end else if (rx_loss_pulse && (rx_loss_cnt != LOSS_CNT_MAX)) begin
      rx_loss_cnt <= rx_loss_cnt + 8'd1;
    end
  end

endmodule

// File: doc/serdes_status_filter.md
# serdes_status_filter

Conditions the raw SERDES status flags (receive CDR loss-of-lock, receive loss-of-signal, transmit PLL loss-of-lock) for the per-channel receive reset sequencer. Each flag is synchronised into the `refclkdiv2` domain and then filtered with an asymmetric debounce: loss is reported quickly, and recovery is reported only after sustained stability. The block also counts receive loss events for diagnostics. It sits directly upstream of the receive reset sequencer and drives its `*_s` status inputs.

## Interface
- `ASSERT_CYC`, default 2: consecutive stable cycles required before a filtered flag rises (loss reported). Legal range 1..255.
- `DEASSERT_CYC`, default 16: consecutive stable cycles required before a filtered flag falls (recovery reported). Legal range 1..255.
- `refclkdiv2`  in  1  block clock.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_cdr_lol_ch`  in  1  raw receive CDR loss-of-lock, asynchronous to the clock.
- `rx_los_low_ch`  in  1  raw receive loss-of-signal, asynchronous.
- `tx_pll_lol_qd`  in  1  raw transmit PLL loss-of-lock, asynchronous. Tie to 0 when the TX quad is unused.
- `clr_cnt`  in  1  synchronous clear of `rx_loss_cnt`.
- `rx_cdr_lol_ch_s`  out  1  filtered CDR loss-of-lock.
- `rx_los_low_ch_s`  out  1  filtered loss-of-signal.
- `tx_pll_lol_qd_s`  out  1  filtered PLL loss-of-lock.
- `rx_loss_pulse`  out  1  one-cycle pulse on each rising edge of (`rx_cdr_lol_ch_s` | `rx_los_low_ch_s`).
- `rx_loss_cnt`  out  8  saturating count of `rx_loss_pulse` events.

## Operation
- Each of the three flags passes through an independent, identical path: a 2-flop synchroniser (`sy1` → `sy2`), then a filter holding `out` and an 8-bit `cnt`.
- Filter rule, evaluated every cycle:
  - If `sy2 == out`: set `cnt` to 0.
  - Otherwise, `cnt` increments. Define the limit as `ASSERT_CYC` when `out` = 0, and `DEASSERT_CYC` when `out` = 1. When `cnt + 1` equals the limit, toggle `out` and set `cnt` to 0.
- Any single cycle in which `sy2` matches `out` restarts the count. Glitches shorter than the limit never reach the outputs.
- Loss-event logic:
  - `loss_now = rx_cdr_lol_ch_s | rx_los_low_ch_s` (registered outputs).
  - `loss_d` is `loss_now` delayed by one cycle.
  - `rx_loss_pulse` is the combinational function `loss_now & ~loss_d`.
- Counter logic:
  - When `clr_cnt` = 1, `rx_loss_cnt` becomes 0. Clear has priority over a simultaneous pulse; that event is lost.
  - Otherwise, when `rx_loss_pulse` = 1 and `rx_loss_cnt` < 255, the counter increments.
  - At 255 the counter holds; it never wraps.
- Reset values:
  - All synchroniser flops and all filtered outputs are 1 (conservative: loss asserted).
  - `loss_d` = 1, so no pulse occurs at reset release.
  - All `cnt` = 0 and `rx_loss_cnt` = 0.
- Reset asserted mid-operation immediately forces every output to its reset value. Filtering restarts from the loss state.
- After reset release with clean inputs (all raw = 0), the filtered flags fall at edge `DEASSERT_CYC` + 2.

## Timing
- Edge numbering: edge 1 is the first rising edge that samples a new raw value into `sy1`. `sy2` updates on edge 2.
- A filtered output toggles on edge (limit + 2), provided the raw value is held throughout.
- Defaults:
  - Loss is reported on edge 4.
  - Recovery is reported on edge 18.
- `rx_loss_pulse` is high in the cycle after the registered output rises, i.e. combinationally from the edge where the output rises until the next edge.
- `rx_loss_cnt` updates on the edge following the pulse.
- The three flags are filtered independently. A skew of one cycle between flags is acceptable to the downstream sequencer.

## Structure
- Shared package contents:
  - Status-filter counter width (8).
  - Reset value of the filtered flags (1).
  - Counter saturation value (255).
- Sub-module `status_flag_filter`:
  - Contains one synchroniser plus the debounce filter.
  - Parameters: `ASSERT_CYC`, `DEASSERT_CYC`.
  - Ports: `refclkdiv2`, `rst`, `raw`, `filt`.
  - Instantiated three times.
- The top level holds the edge detector and event counter only.

## Test plan
- Reset release with all raw inputs = 0 → all three `*_s` outputs stay 1 through edge 17 and fall on edge 18. `rx_loss_pulse` never fires. `rx_loss_cnt` = 0.
- From the settled state, pulse `rx_cdr_lol_ch` high for 1 cycle → no output change. Hold it high for 3 cycles → `rx_cdr_lol_ch_s` rises on edge 4, `rx_loss_pulse` fires once, and `rx_loss_cnt` = 1.
- With `rx_cdr_lol_ch_s` = 1, drop the raw input, re-raise it after 10 cycles, then drop it for good → the output stays 1 until 16 consecutive low cycles have passed after the final drop.
- Generate 300 loss/recovery events on `rx_los_low_ch` → `rx_loss_cnt` saturates at 255. Pulse `clr_cnt` in the same cycle as a `rx_loss_pulse` → count is 0 afterwards.
- Raise `rx_cdr_lol_ch` and `rx_los_low_ch` together → both filtered flags rise on the same edge, with exactly one pulse and a count increment of 1.
- Assert `rst` while `tx_pll_lol_qd_s` = 0 and its filter count is mid-way → all outputs return to 1 asynchronously and `rx_loss_cnt` = 0. After release, recovery again takes 18 edges.
